ram_arbiter: RTL

Two-port arbiter that shares the single-port data RAM between the CPU load/store path and the host bridge loader/debugger. Each requester uses a req/gnt handshake. The arbiter drives the RAM for exactly one winner per cycle and returns read data to that winner one cycle later with a `rvalid` strobe. It sits between the core's memory stage, the bridge command logic and the `ram` instance. It never modifies data or addresses beyond word-index extraction.

---
 rtl/ram_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port req/gnt arbiter sharing one single-port RAM between the CPU and the host bridge.
// Define RAM_ARB_HOST_PRIO_EN for fixed host priority instead of round-robin.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [31:0]       host_addr,
    input  logic [3:0]        host_be,
    input  logic [31:0]       host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic {
        PortCpu  = 1'b0,
        PortHost = 1'b1
    } port_e;

    port_e last_q, last_d;
    logic  rd_pend_q, rd_pend_d;
    port_e rd_owner_q, rd_owner_d;

    logic cpu_win, host_win;

    // Only the word-index bits of each byte address reach the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                host_addr[31:ADDR_W+2], host_addr[1:0]};

    always_comb begin
        cpu_win  = 1'b0;
        host_win = 1'b0;
        if (!reset) begin
`ifdef RAM_ARB_HOST_PRIO_EN
            host_win = host_req;
            cpu_win  = cpu_req && !host_req;
`else
            if (cpu_req && host_req) begin
                cpu_win  = (last_q == PortHost);
                host_win = (last_q == PortCpu);
            end else begin
                cpu_win  = cpu_req;
                host_win = host_req;
            end
`endif
        end
    end

    always_comb begin
        ram_en    = cpu_win || host_win;
        ram_we    = 1'b0;
        ram_be    = 4'hF;
        ram_addr  = cpu_addr[ADDR_W+1:2];
        ram_wdata = cpu_wdata;
        if (host_win) begin
            ram_we    = host_we;
            ram_be    = host_we ? host_be : 4'hF;
            ram_addr  = host_addr[ADDR_W+1:2];
            ram_wdata = host_wdata;
        end else if (cpu_win) begin
            ram_we    = cpu_we;
            ram_be    = cpu_we ? cpu_be : 4'hF;
        end
    end

    always_comb begin
        last_d     = last_q;
        rd_pend_d  = ram_en && !ram_we;
        rd_owner_d = host_win ? PortHost : PortCpu;
        if (host_win) begin
            last_d = PortHost;
        end else if (cpu_win) begin
            last_d = PortCpu;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= PortHost;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PortCpu;
        end else begin
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_gnt     = cpu_win;
    assign host_gnt    = host_win;
    assign cpu_rvalid  = rd_pend_q && (rd_owner_q == PortCpu);
    assign host_rvalid = rd_pend_q && (rd_owner_q == PortHost);
    assign cpu_rdata   = ram_rdata;
    assign host_rdata  = ram_rdata;

endmodule
